// File: rtl/add_sub_carry_pipe.sv
// add_sub_carry_pipe: pipelined W-bit adder/subtractor split into S segments of
// G = W/S bits. Each stage resolves one segment and hands its carry to the next.
// The result is (W+1) bits, and its MSB is the carry (add) or the borrow (sub).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready is combinational)
//   op_mode            0 = A+B, 1 = A-B
//   Data_A, Data_B     W-bit operands
//   out_valid/out_ready result handshake
//   Data_S             (W+1)-bit result, with bit W = carry/borrow
//   ovf                signed overflow of Data_S[W-1:0]
//   zero               Data_S[W-1:0] == 0
module add_sub_carry_pipe #(
  parameter int unsigned W = 32,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_mode,
  input  logic [W-1:0] Data_A,
  input  logic [W-1:0] Data_B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   Data_S,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned G  = W / S;
  localparam int unsigned P  = (S > 1) ? S - 1 : 1;
  localparam int          SI = int'(S);
  localparam int          NP = SI - 1;

  // Inter-stage registers. The operands are shifted right one segment per stage,
  // so the segment being resolved is always at bits [G-1:0]. The resolved sum
  // segments are shifted in from the top.
  logic [W-1:0] a_q  [P];
  logic [W-1:0] b_q  [P];
  logic [W-1:0] s_q  [P];
  logic         c_q  [P];
  logic         op_q [P];
  logic         v_q  [P];

  // Inputs seen by each stage (stage 0 reads the ports).
  logic [W-1:0] a_src  [S];
  logic [W-1:0] b_src  [S];
  logic [W-1:0] s_src  [S];
  logic         c_src  [S];
  logic         op_src [S];
  logic         v_src  [S];
  logic [G-1:0] bx     [S];
  logic [G:0]   seg    [S];
  logic [W-1:0] s_nxt  [S];

  logic en;

  // Global advance: the whole pipe moves unless a result is waiting and blocked.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Per-stage segment add; subtract is A + ~B + 1 with carry-in op_mode.
  always_comb begin
    a_src[0]  = Data_A;
    b_src[0]  = Data_B;
    s_src[0]  = '0;
    c_src[0]  = op_mode;
    op_src[0] = op_mode;
    v_src[0]  = in_valid;
    for (int k = 1; k < SI; k++) begin
      a_src[k]  = a_q[k-1];
      b_src[k]  = b_q[k-1];
      s_src[k]  = s_q[k-1];
      c_src[k]  = c_q[k-1];
      op_src[k] = op_q[k-1];
      v_src[k]  = v_q[k-1];
    end
    for (int k = 0; k < SI; k++) begin
      bx[k]    = op_src[k] ? ~b_src[k][G-1:0] : b_src[k][G-1:0];
      seg[k]   = (G+1)'(a_src[k][G-1:0]) + (G+1)'(bx[k]) + (G+1)'(c_src[k]);
      s_nxt[k] = (s_src[k] >> G) | (W'(seg[k][G-1:0]) << (W - G));
    end
  end

  // Stage registers and the output stage. The data registers load only with a
  // valid beat, so the outputs keep their reset values until the first result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(P); k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        op_q[k] <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      out_valid <= 1'b0;
      Data_S    <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NP; k++) begin
        v_q[k] <= v_src[k];
        if (v_src[k]) begin
          a_q[k]  <= a_src[k] >> G;
          b_q[k]  <= b_src[k] >> G;
          s_q[k]  <= s_nxt[k];
          c_q[k]  <= seg[k][G];
          op_q[k] <= op_src[k];
        end
      end
      out_valid <= v_src[S-1];
      if (v_src[S-1]) begin
        // In subtract mode, an absent carry-out means a borrow.
        Data_S <= {op_src[S-1] ^ seg[S-1][G], s_nxt[S-1]};
        // Overflow: the effective operand signs agree, but the sign of the sum differs.
        ovf    <= (a_src[S-1][G-1] == bx[S-1][G-1]) &&
                  (seg[S-1][G-1] != a_src[S-1][G-1]);
        zero   <= (s_nxt[S-1] == '0);
      end
    end
  end

endmodule
